// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_flags family: read-mode encoding and
// parameter helper functions used at elaboration time.
package fifo_pkg;

  // Read-port behaviour: registered pop data or first-word-fall-through head.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } read_mode_e;

  // Count/pointer width: one extra bit so that a completely full FIFO (DEPTH)
  // is representable and the pointer MSB can act as a wrap bit.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True for powers of two that are at least 2.
  function automatic bit fifo_is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, asynchronous read.
// No reset on the array; contents are only meaningful where the FIFO says so.
module fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the accepted word at the write address.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port is combinational so the FWFT head is visible without a bubble.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty, standard or FWFT read mode and sticky
// overflow/underflow error flags. Single clock domain, synchronous reset.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int WIDTH         = 8,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0,
  localparam int CW           = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int AW = CW - 1;
  localparam read_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  // Reject configurations the pointer arithmetic and flags cannot support.
  if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_THRESH=%0d outside 1..DEPTH", AFULL_THRESH);
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_THRESH=%0d outside 0..DEPTH-1", AEMPTY_THRESH);
  end

  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_almost_empty;
  logic             r_almost_full;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_mem_rd;

  // A read is only honoured when there is data; a write into a full FIFO is
  // honoured only when a same-cycle read frees the slot.
  assign w_rd_ok   = read_en & ~r_empty;
  assign w_wr_ok   = write_en & (~r_full | w_rd_ok);
  assign w_ovf_set = write_en & ~w_wr_ok;
  assign w_unf_set = read_en & r_empty;

  assign w_count_next = r_count
                      + {{(CW-1){1'b0}}, w_wr_ok}
                      - {{(CW-1){1'b0}}, w_rd_ok};

  // The wrap bits are carried for debug visibility of the pointer lap; the
  // occupancy itself comes from the count register.
  logic w_unused_wrap;
  assign w_unused_wrap = r_wr_ptr[CW-1] ^ r_rd_ptr[CW-1];

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_mem_rd)
  );

  // Pointer advance; the CW-bit pointers wrap naturally at 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy and all level flags registered from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
    end else begin
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == DEPTH_C);
      r_almost_empty <= (w_count_next <= AEMPTY_C);
      r_almost_full  <= (w_count_next >= AFULL_C);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (clear_err) r_overflow <= 1'b0;
      if (w_unf_set)      r_underflow <= 1'b1;
      else if (clear_err) r_underflow <= 1'b0;
    end
  end

  // Output stage differs by read mode.
  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head entry is presented directly; zero while nothing is held.
    assign data_out   = r_empty ? '0 : w_mem_rd;
    assign data_valid = ~r_empty;
  end else begin : g_std
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;

    // Capture the head on an accepted read; hold it otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_out   <= '0;
        r_data_valid <= 1'b0;
      end else begin
        r_data_valid <= w_rd_ok;
        if (w_rd_ok) r_data_out <= w_mem_rd;
      end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
  end

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
